// File: rtl/multi7_share.sv
// multi7_share: round-robin time-slicing of one seven-segment driver between
// several requesters. Each owner is shown for at least a dwell time when there
// is contention, and a blank gap separates consecutive owners.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nobody requesting, all outputs low
//   SHOW  | one requester owns the display, its word is forwarded
//   GAP   | display blanked between owners for BLANK_CYCLES cycles
module multi7_share #(
    parameter int DIGITS       = 8,
    parameter int REQS         = 2,
    parameter int DWELL_CYCLES = 10_000_000,
    parameter int BLANK_CYCLES = 100_000
) (
    input  logic                       i_clk_10mhz,
    input  logic                       i_rst,
    input  logic [REQS-1:0]            i_req,
    input  logic [REQS*DIGITS*4-1:0]   i_digits_all,
    output logic [REQS-1:0]            o_grant,
    output logic [DIGITS*4-1:0]        o_digits,
    output logic                       o_blank,
    output logic                       o_busy
);

    localparam int WW   = DIGITS * 4;
    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int PW   = (REQS > 1) ? $clog2(REQS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [PW-1:0] LAST_RST   = PW'(REQS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_last;
    logic [CW-1:0]   r_cnt;

    logic            w_win_found;
    logic [PW-1:0]   w_win_idx;
    logic [REQS-1:0] w_win_onehot;
    logic [WW-1:0]   w_win_word;
    logic [WW-1:0]   w_owner_word;
    logic            w_own_req;
    logic            w_others;
    logic            w_dwell_expired;
    logic            w_gap_done;
    int              w_scan;

    // Round-robin scan starting just after the last owner, wrapping around.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = 0;
        for (int i = 1; i <= REQS; i++) begin
            w_scan = (int'(r_last) + i) % REQS;
            if (!w_win_found && i_req[w_scan]) begin
                w_win_found = 1'b1;
                w_win_idx   = PW'(w_scan);
            end
        end
    end

    // Winner/owner data selection and SHOW exit conditions.
    always_comb begin
        w_win_onehot    = {{(REQS-1){1'b0}}, 1'b1} << w_win_idx;
        w_win_word      = i_digits_all[int'(w_win_idx)*WW +: WW];
        w_owner_word    = i_digits_all[int'(r_last)*WW +: WW];
        w_own_req       = i_req[r_last];
        w_others        = |(i_req & ~o_grant);
        w_dwell_expired = (r_cnt == DWELL_LAST);
        w_gap_done      = (r_cnt == BLANK_LAST);
    end

    // Sequencer with registered outputs; the owner index lives in r_last.
    always_ff @(posedge i_clk_10mhz) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_last   <= LAST_RST;
            r_cnt    <= '0;
            o_grant  <= '0;
            o_digits <= '0;
            o_blank  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        r_state  <= S_SHOW;
                        r_last   <= w_win_idx;
                        r_cnt    <= '0;
                        o_grant  <= w_win_onehot;
                        o_digits <= w_win_word;
                        o_blank  <= 1'b0;
                        o_busy   <= 1'b1;
                    end else begin
                        o_grant  <= '0;
                        o_digits <= '0;
                        o_blank  <= 1'b0;
                        o_busy   <= 1'b0;
                    end
                end
                S_SHOW: begin
                    if (!w_own_req || (w_dwell_expired && w_others)) begin
                        r_state  <= S_GAP;
                        r_cnt    <= '0;
                        o_grant  <= '0;
                        o_digits <= '0;
                        o_blank  <= 1'b1;
                        o_busy   <= 1'b1;
                    end else begin
                        o_digits <= w_owner_word;
                        // Saturate so an uncontested owner never wraps the counter.
                        if (!w_dwell_expired) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        if (w_win_found) begin
                            r_state  <= S_SHOW;
                            r_last   <= w_win_idx;
                            r_cnt    <= '0;
                            o_grant  <= w_win_onehot;
                            o_digits <= w_win_word;
                            o_blank  <= 1'b0;
                            o_busy   <= 1'b1;
                        end else begin
                            r_state  <= S_IDLE;
                            r_cnt    <= '0;
                            o_grant  <= '0;
                            o_digits <= '0;
                            o_blank  <= 1'b0;
                            o_busy   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    o_grant  <= '0;
                    o_digits <= '0;
                    o_blank  <= 1'b0;
                    o_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi7_share.sv
// Bench for multi7_share: a cycle-level reference model pushes the expected
// outputs for every clock edge into a queue; an independent monitor pops and
// compares. Directed scenarios add a few fixed-value checks on top.
module tb_multi7_share;

    localparam int DIGITS = 8;
    localparam int REQS   = 3;
    localparam int DWELL  = 5;
    localparam int BLANK  = 2;
    localparam int WW     = DIGITS * 4;

    typedef struct {
        logic [REQS-1:0] grant;
        logic [WW-1:0]   digits;
        logic            blank;
        logic            busy;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [REQS-1:0]       req;
    logic [REQS*WW-1:0]    dig;
    logic [REQS-1:0]       o_grant;
    logic [WW-1:0]         o_digits;
    logic                  o_blank;
    logic                  o_busy;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    multi7_share #(
        .DIGITS(DIGITS), .REQS(REQS), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
    ) dut (
        .i_clk_10mhz (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_digits_all(dig),
        .o_grant     (o_grant),
        .o_digits    (o_digits),
        .o_blank     (o_blank),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requester at or after last+1 (with wrap), -1 if none.
    function automatic int arb(input logic [REQS-1:0] r, input int lst);
        for (int i = 1; i <= REQS; i++) begin
            if (r[(lst + i) % REQS]) return (lst + i) % REQS;
        end
        return -1;
    endfunction

    // Reference model: mode 0 idle, 1 showing, 2 blank gap.
    int m_mode, m_owner, m_last, m_shown, m_gap;
    initial begin
        logic [REQS-1:0] one;
        logic            oth;
        int              w;
        exp_t            e;
        one     = 1;
        m_mode  = 0;
        m_owner = -1;
        m_last  = REQS - 1;
        m_shown = 0;
        m_gap   = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_mode  = 0;
                m_owner = -1;
                m_last  = REQS - 1;
            end else if (m_mode == 0) begin
                w = arb(req, m_last);
                if (w >= 0) begin
                    m_mode = 1; m_owner = w; m_last = w; m_shown = 0;
                end
            end else if (m_mode == 1) begin
                m_shown++;
                oth = ((req & ~(one << m_owner)) != 0);
                if (!req[m_owner] || (m_shown >= DWELL && oth)) begin
                    m_mode = 2; m_gap = 0; m_owner = -1;
                end
            end else begin
                m_gap++;
                if (m_gap >= BLANK) begin
                    w = arb(req, m_last);
                    if (w >= 0) begin
                        m_mode = 1; m_owner = w; m_last = w; m_shown = 0;
                    end else begin
                        m_mode = 0;
                    end
                end
            end
            e.grant  = '0;
            e.digits = '0;
            e.blank  = 1'b0;
            e.busy   = 1'b0;
            if (m_mode == 1) begin
                e.grant  = one << m_owner;
                e.digits = dig[m_owner*WW +: WW];
                e.busy   = 1'b1;
            end else if (m_mode == 2) begin
                e.blank = 1'b1;
                e.busy  = 1'b1;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL model_queue_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (o_grant !== e.grant || o_digits !== e.digits ||
                    o_blank !== e.blank || o_busy !== e.busy) begin
                    n_err++;
                    $display("FAIL cycle_outputs t=%0t got grant=%b digits=%h blank=%b busy=%b want grant=%b digits=%h blank=%b busy=%b",
                             $time, o_grant, o_digits, o_blank, o_busy,
                             e.grant, e.digits, e.blank, e.busy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {o_grant, o_digits, o_blank, o_busy}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [REQS-1:0] seq [15];
        // 1: reset with random inputs
        rst = 1'b1;
        req = REQS'($urandom);
        dig = {$urandom, $urandom, $urandom};
        tick(); check_zero("reset_cycle1");
        req = REQS'($urandom);
        dig = {$urandom, $urandom, $urandom};
        tick(); check_zero("reset_cycle2");

        // 2: single uncontested owner, then drop
        rst = 1'b0;
        req = 3'b001;
        dig[0 +: WW] = 32'h1234_5678;
        tick();
        check("s2_grant", 64'(o_grant), 64'h1);
        check("s2_digits", 64'(o_digits), 64'h1234_5678);
        repeat (20) tick();
        check("s2_grant_after20", 64'(o_grant), 64'h1);
        req = 3'b000;
        tick(); check("s2_blank1", 64'(o_blank), 64'h1);
        tick(); check("s2_blank2", 64'(o_blank), 64'h1);
        tick(); check("s2_idle_busy", 64'({o_busy, o_blank}), 64'h0);

        // 3: req0 and req2 together from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b101;
        for (int i = 0; i < 15; i++) begin
            if (i < 5) seq[i] = 3'b001;
            else if (i < 7) seq[i] = 3'b000;
            else if (i < 12) seq[i] = 3'b100;
            else if (i < 14) seq[i] = 3'b000;
            else seq[i] = 3'b001;
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("s3_grant_%0d", i), 64'(o_grant), 64'(seq[i]));
        end

        // 4: all three requesting, order 0,1,2,0 every 7 cycles
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i % 7 == 0)
                check($sformatf("s4_owner_%0d", i / 7), 64'(o_grant), 64'(3'b001 << ((i / 7) % 3)));
        end

        // 5: owner data change follows one cycle later
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b010;
        dig[WW +: WW] = 32'hDEAD_BEEF;
        repeat (3) tick();
        check("s5_digits_before", 64'(o_digits), 64'hDEAD_BEEF);
        dig[WW +: WW] = 32'hCAFE_F00D;
        tick();
        check("s5_digits_after", 64'(o_digits), 64'hCAFE_F00D);
        check("s5_grant", 64'(o_grant), 64'h2);

        // 6: reset in the third SHOW cycle of owner 1
        rst = 1'b1; tick(); rst = 1'b0;
        req = 3'b110;
        tick(); check("s6_grant_show", 64'(o_grant), 64'h2);
        tick(); tick();
        rst = 1'b1;
        tick(); check_zero("s6_after_reset");
        rst = 1'b0;
        tick(); check("s6_regrant", 64'(o_grant), 64'h2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < REQS; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            if ($urandom_range(3) == 0) dig = {$urandom, $urandom, $urandom};
            rst = ($urandom_range(63) == 0);
            tick();
        end

        rst = 1'b0;
        req = '0;
        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
